// File: rtl/alu_stage.sv
// alu_stage: a 32-bit ADD/SUB/AND/ORR ALU whose results go into a
// 2-entry in-order output buffer with a valid/ready handshake on both sides.
// The architectural NZCV register loads the flags of entries that have their
// set-flags bit, at the moment they leave the buffer.
module alu_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    input  logic [1:0]  ALUControl,
    input  logic        S,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] ALUResult,
    output logic [3:0]  ALUFlags,
    output logic [3:0]  Flags
);

    // Buffer occupancy; FULL blocks upstream, EMPTY hides the outputs.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;

    occ_e        state_q, state_d;
    logic        wrPtr_q, wrPtr_d;
    logic        rdPtr_q, rdPtr_d;
    logic [3:0]  archFlags_q, archFlags_d;

    logic [31:0] resultMem_q [2];
    logic [3:0]  flagsMem_q  [2];
    logic        sMem_q      [2];

    logic [31:0] effB;
    logic [32:0] sum;
    logic [31:0] aluRes;
    logic        carry;
    logic        overflow;
    logic [3:0]  aluFlags;

    logic        accept;
    logic        pop;

    // SUB reuses the adder as SrcA + ~SrcB + 1, so C means "no borrow".
    always_comb begin
        effB     = ALUControl[0] ? ~SrcB : SrcB;
        sum      = {1'b0, SrcA} + {1'b0, effB} + {32'd0, ALUControl[0]};
        aluRes   = sum[31:0];
        carry    = 1'b0;
        overflow = 1'b0;
        case (ALUControl)
            2'b00, 2'b01: begin
                aluRes   = sum[31:0];
                carry    = sum[32];
                overflow = (SrcA[31] == effB[31]) && (sum[31] != SrcA[31]);
            end
            2'b10: aluRes = SrcA & SrcB;
            2'b11: aluRes = SrcA | SrcB;
        endcase
        aluFlags = {aluRes[31], (aluRes == 32'd0), carry, overflow};
    end

    // in_ready is held low while reset is asserted, even though the state is EMPTY.
    assign in_ready  = reset && (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Occupancy, pointer and architectural-flag next-state logic.
    always_comb begin
        state_d     = state_q;
        wrPtr_d     = wrPtr_q ^ accept;
        rdPtr_d     = rdPtr_q ^ pop;
        archFlags_d = archFlags_q;
        case (state_q)
            EMPTY: begin
                if (accept) state_d = ONE;
            end
            ONE: begin
                if (accept && !pop)      state_d = FULL;
                else if (!accept && pop) state_d = EMPTY;
                else                     state_d = ONE;
            end
            FULL: begin
                if (pop) state_d = ONE;
            end
            default: state_d = EMPTY;
        endcase
        if (pop && sMem_q[rdPtr_q]) archFlags_d = flagsMem_q[rdPtr_q];
    end

    // Control state; reset drops any buffered entries without touching Flags from them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= EMPTY;
            wrPtr_q     <= 1'b0;
            rdPtr_q     <= 1'b0;
            archFlags_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            archFlags_q <= archFlags_d;
        end
    end

    // Buffer storage; entries are cleared on reset so the outputs read zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                resultMem_q[i] <= 32'd0;
                flagsMem_q[i]  <= 4'd0;
                sMem_q[i]      <= 1'b0;
            end
        end else if (accept) begin
            resultMem_q[wrPtr_q] <= aluRes;
            flagsMem_q[wrPtr_q]  <= aluFlags;
            sMem_q[wrPtr_q]      <= S;
        end
    end

    assign ALUResult = resultMem_q[rdPtr_q];
    assign ALUFlags  = flagsMem_q[rdPtr_q];
    assign Flags     = archFlags_q;

endmodule

// File: tb/tb_alu_stage.sv
// tb_alu_stage: directed-vector bench for alu_stage with hand-computed results.
module tb_alu_stage;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [1:0]  ALUControl;
    logic        S;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALUResult;
    logic [3:0]  ALUFlags;
    logic [3:0]  Flags;

    int checkCount = 0;
    int errorCount = 0;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_ORR = 2'b11;

    alu_stage dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .ALUControl (ALUControl),
        .S          (S),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ALUResult  (ALUResult),
        .ALUFlags   (ALUFlags),
        .Flags      (Flags)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] ctl, input logic [31:0] a,
                                 input logic [31:0] b, input logic s);
        in_valid   = 1'b1;
        ALUControl = ctl;
        SrcA       = a;
        SrcB       = b;
        S          = s;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    // One op through an empty buffer with out_ready=1: result visible one cycle
    // after accept, Flags updated after the following pop edge.
    task automatic singleOp(input string tag, input logic [1:0] ctl,
                            input logic [31:0] a, input logic [31:0] b, input logic s,
                            input logic [31:0] expRes, input logic [3:0] expNzcv,
                            input logic [3:0] expFlags);
        applyStimulus(ctl, a, b, s);
        tick();
        idle();
        checkOutput({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        checkOutput({tag, "_res"}, ALUResult, expRes);
        checkOutput({tag, "_nzcv"}, {28'd0, ALUFlags}, {28'd0, expNzcv});
        tick();
        checkOutput({tag, "_flags"}, {28'd0, Flags}, {28'd0, expFlags});
        checkOutput({tag, "_empty"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        reset      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        SrcA       = 32'd0;
        SrcB       = 32'd0;
        ALUControl = OP_ADD;
        S          = 1'b0;

        #3;
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("rst_result", ALUResult, 32'd0);
        checkOutput("rst_aluflags", {28'd0, ALUFlags}, 32'd0);
        checkOutput("rst_flags", {28'd0, Flags}, 32'd0);

        #9 reset = 1'b1;
        tick();
        checkOutput("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        out_ready = 1'b1;
        singleOp("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1,
                 32'h8000_0000, 4'b1001, 4'b1001);
        singleOp("sub_eq", OP_SUB, 32'h0000_0005, 32'h0000_0005, 1'b1,
                 32'h0000_0000, 4'b0110, 4'b0110);
        singleOp("sub_neg", OP_SUB, 32'h0000_0000, 32'h0000_0001, 1'b1,
                 32'hFFFF_FFFF, 4'b1000, 4'b1000);
        singleOp("and_nos", OP_AND, 32'hFF1C_10E7, 32'h0000_FFFF, 1'b0,
                 32'h0000_10E7, 4'b0000, 4'b1000);
        singleOp("orr", OP_ORR, 32'h8000_00F0, 32'h0000_000F, 1'b1,
                 32'h8000_00FF, 4'b1000, 4'b1000);
        singleOp("add_carry", OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1,
                 32'h0000_0000, 4'b0110, 4'b0110);
        singleOp("and_s_clears_cv", OP_AND, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1,
                 32'h0000_0001, 4'b0000, 4'b0000);

        // Backpressure: two entries fill the buffer, the third is held upstream.
        out_ready = 1'b0;
        applyStimulus(OP_ADD, 32'd1, 32'd1, 1'b0);
        tick();
        checkOutput("bp_in_ready_one", {31'd0, in_ready}, 32'd1);
        applyStimulus(OP_ADD, 32'd2, 32'd2, 1'b0);
        tick();
        checkOutput("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
        applyStimulus(OP_ADD, 32'd3, 32'd3, 1'b0);
        tick();
        tick();
        checkOutput("bp_hold_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("bp_stable_res", ALUResult, 32'd2);
        checkOutput("bp_stable_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        tick();
        checkOutput("bp_second", ALUResult, 32'd4);
        tick();
        idle();
        checkOutput("bp_third", ALUResult, 32'd6);
        checkOutput("bp_third_valid", {31'd0, out_valid}, 32'd1);
        tick();
        checkOutput("bp_drained", {31'd0, out_valid}, 32'd0);

        // Streaming: accept and pop every cycle while the buffer holds one entry.
        applyStimulus(OP_ADD, 32'd0, 32'd100, 1'b0);
        tick();
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(OP_ADD, i, 32'd100, 1'b0);
            checkOutput($sformatf("stream_res%0d", i - 1), ALUResult, 32'd100 + (i - 1));
            checkOutput($sformatf("stream_ready%0d", i - 1), {31'd0, in_ready}, 32'd1);
            tick();
        end
        idle();
        checkOutput("stream_last", ALUResult, 32'd110);
        tick();
        checkOutput("stream_drained", {31'd0, out_valid}, 32'd0);

        // Reset with a full buffer: entries vanish and Flags clears at once.
        singleOp("pre_rst", OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1,
                 32'h8000_0000, 4'b1001, 4'b1001);
        out_ready = 1'b0;
        applyStimulus(OP_SUB, 32'd0, 32'd1, 1'b1);
        tick();
        applyStimulus(OP_ADD, 32'd5, 32'd5, 1'b1);
        tick();
        idle();
        checkOutput("midrst_full", {31'd0, in_ready}, 32'd0);
        #2 reset = 1'b0;
        #1;
        checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("midrst_flags", {28'd0, Flags}, 32'd0);
        checkOutput("midrst_result", ALUResult, 32'd0);
        #3 reset = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        checkOutput("postrst_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("postrst_flags", {28'd0, Flags}, 32'd0);
        checkOutput("postrst_ready", {31'd0, in_ready}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
